// File: rtl/sriov_pkg.sv
// Shared types and constants for the SR-IOV VF Enable sequencer.
package sriov_pkg;

  localparam int unsigned SRIOV_NUMVFS_W        = 16;
  localparam int unsigned SRIOV_SETTLE_DEFAULT  = 1024;
  localparam int unsigned SRIOV_QUIESCE_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_DISABLED   = 3'd0,
    ST_SETTLE     = 3'd1,
    ST_ENABLED    = 3'd2,
    ST_QUIESCE    = 3'd3,
    ST_RESET_WALK = 3'd4
  } sriov_vf_state_e;

  // NumVFs above TotalVFs is clamped rather than rejected.
  function automatic logic [SRIOV_NUMVFS_W-1:0] clamp_num_vfs(
    input logic [SRIOV_NUMVFS_W-1:0] req,
    input int unsigned               total
  );
    if (32'(req) > total) return SRIOV_NUMVFS_W'(total);
    return req;
  endfunction

endpackage

// File: rtl/sriov_vf_enable_seq_if.sv
// Control-write, quiesce and per-VF reset handshake signals of the VF Enable sequencer.
interface sriov_vf_enable_seq_if
  import sriov_pkg::*;
#(
  parameter int unsigned VF_ID_W = 4
);

  logic                      ctrl_wr_en;
  logic                      ctrl_vf_enable;
  logic [SRIOV_NUMVFS_W-1:0] ctrl_num_vfs;
  logic                      vf_outstanding;
  logic                      vf_rst_ready;
  logic                      vf_rst_valid;
  logic [VF_ID_W-1:0]        vf_rst_id;
  logic [SRIOV_NUMVFS_W-1:0] num_vfs_q;
  logic                      vf_access_en;
  logic                      vf_cfg_rrs;
  logic                      busy;
  logic                      wr_reject;
  logic                      quiesce_to;

  modport master (
    output ctrl_wr_en, ctrl_vf_enable, ctrl_num_vfs, vf_outstanding, vf_rst_ready,
    input  vf_rst_valid, vf_rst_id, num_vfs_q, vf_access_en, vf_cfg_rrs, busy,
           wr_reject, quiesce_to
  );

  modport slave (
    input  ctrl_wr_en, ctrl_vf_enable, ctrl_num_vfs, vf_outstanding, vf_rst_ready,
    output vf_rst_valid, vf_rst_id, num_vfs_q, vf_access_en, vf_cfg_rrs, busy,
           wr_reject, quiesce_to
  );

endinterface

// File: rtl/sriov_cycle_timer.sv
// Loadable down-counter shared by the settle and quiesce timeouts; holds at zero.
module sriov_cycle_timer #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/sriov_vf_enable_seq.sv
// SR-IOV VF Enable sequencer: settle with RRS on enable; quiesce then walk per-VF resets on disable.
module sriov_vf_enable_seq
  import sriov_pkg::*;
#(
  parameter int unsigned TOTAL_VFS       = 16,
  parameter int unsigned SETTLE_CYCLES   = SRIOV_SETTLE_DEFAULT,
  parameter int unsigned QUIESCE_TIMEOUT = SRIOV_QUIESCE_DEFAULT,
  parameter int unsigned VF_ID_W         = (TOTAL_VFS > 1) ? $clog2(TOTAL_VFS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  sriov_vf_enable_seq_if.slave bus
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > QUIESCE_TIMEOUT) ? SETTLE_CYCLES
                                                                      : QUIESCE_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  sriov_vf_state_e           state_q, state_d;
  logic [VF_ID_W-1:0]        idx_q, idx_d;
  logic [SRIOV_NUMVFS_W-1:0] num_q, num_d;
  logic [SRIOV_NUMVFS_W-1:0] num_clamp;
  logic                      wr_reject_q, wr_reject_d;
  logic                      quiesce_to_q, quiesce_to_d;
  logic                      vf_rst_valid_q, vf_rst_valid_d;
  logic                      vf_access_en_q, vf_access_en_d;
  logic                      vf_cfg_rrs_q, vf_cfg_rrs_d;
  logic                      busy_q, busy_d;
  logic                      tmr_load;
  logic [TMR_W-1:0]          tmr_val;
  logic                      tmr_expired;
  logic                      last_vf;

  sriov_cycle_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign num_clamp = clamp_num_vfs(bus.ctrl_num_vfs, TOTAL_VFS);
  assign last_vf   = (SRIOV_NUMVFS_W'(idx_q) + SRIOV_NUMVFS_W'(1)) >= num_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_DISABLED;
      idx_q        <= '0;
      num_q        <= '0;
      wr_reject_q  <= 1'b0;
      quiesce_to_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      num_q        <= num_d;
      wr_reject_q  <= wr_reject_d;
      quiesce_to_q <= quiesce_to_d;
    end
  end

  // Next-state; a write strobe takes priority over timer expiry
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    num_d        = num_q;
    wr_reject_d  = 1'b0;
    quiesce_to_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    unique case (state_q)
      ST_DISABLED: begin
        if (bus.ctrl_wr_en) begin
          num_d = num_clamp;
          if (bus.ctrl_vf_enable) begin
            if (num_clamp == '0) begin
              wr_reject_d = 1'b1;
            end else begin
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
            end
          end
        end
      end
      ST_SETTLE: begin
        if (bus.ctrl_wr_en) begin
          if (!bus.ctrl_vf_enable) begin
            state_d  = ST_QUIESCE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(QUIESCE_TIMEOUT - 1);
          end else begin
            wr_reject_d = 1'b1;
          end
        end else if (tmr_expired) begin
          state_d = ST_ENABLED;
        end
      end
      ST_ENABLED: begin
        if (bus.ctrl_wr_en) begin
          if (!bus.ctrl_vf_enable) begin
            state_d  = ST_QUIESCE;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(QUIESCE_TIMEOUT - 1);
          end else if (bus.ctrl_num_vfs != num_q) begin
            wr_reject_d = 1'b1;
          end
        end
      end
      ST_QUIESCE: begin
        wr_reject_d = bus.ctrl_wr_en;
        if (!bus.vf_outstanding) begin
          state_d = ST_RESET_WALK;
          idx_d   = '0;
        end else if (tmr_expired) begin
          state_d      = ST_RESET_WALK;
          idx_d        = '0;
          quiesce_to_d = 1'b1;
        end
      end
      ST_RESET_WALK: begin
        wr_reject_d = bus.ctrl_wr_en;
        if (bus.vf_rst_ready) begin
          if (last_vf) begin
            state_d = ST_DISABLED;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + VF_ID_W'(1);
          end
        end
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    vf_rst_valid_d = (state_d == ST_RESET_WALK);
    vf_access_en_d = (state_d == ST_ENABLED);
    vf_cfg_rrs_d   = (state_d == ST_SETTLE) || (state_d == ST_QUIESCE) ||
                     (state_d == ST_RESET_WALK);
    busy_d         = vf_cfg_rrs_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vf_rst_valid_q <= 1'b0;
      vf_access_en_q <= 1'b0;
      vf_cfg_rrs_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      vf_rst_valid_q <= vf_rst_valid_d;
      vf_access_en_q <= vf_access_en_d;
      vf_cfg_rrs_q   <= vf_cfg_rrs_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.vf_rst_valid = vf_rst_valid_q;
  assign bus.vf_rst_id    = idx_q;
  assign bus.num_vfs_q    = num_q;
  assign bus.vf_access_en = vf_access_en_q;
  assign bus.vf_cfg_rrs   = vf_cfg_rrs_q;
  assign bus.busy         = busy_q;
  assign bus.wr_reject    = wr_reject_q;
  assign bus.quiesce_to   = quiesce_to_q;

endmodule

// File: tb/tb_sriov_vf_enable_seq.sv
// Directed bench for sriov_vf_enable_seq with a reset-walk scoreboard.
module tb_sriov_vf_enable_seq;

  localparam int unsigned TOTAL   = 16;
  localparam int unsigned SETTLE  = 8;
  localparam int unsigned QTO     = 16;
  localparam int unsigned ID_W    = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [ID_W-1:0] exp_q[$];

  sriov_vf_enable_seq_if #(.VF_ID_W(ID_W)) bus ();

  sriov_vf_enable_seq #(
    .TOTAL_VFS       (TOTAL),
    .SETTLE_CYCLES   (SETTLE),
    .QUIESCE_TIMEOUT (QTO),
    .VF_ID_W         (ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic en, input logic [15:0] n);
    bus.ctrl_wr_en     = 1'b1;
    bus.ctrl_vf_enable = en;
    bus.ctrl_num_vfs   = n;
    tick();
    bus.ctrl_wr_en     = 1'b0;
  endtask

  // Count RRS cycles following an accepted enable write, then expect ENABLED.
  task automatic settle_and_check(input string tag);
    int cnt = 0;
    while (bus.vf_cfg_rrs && cnt < 100) begin
      cnt++;
      tick();
    end
    check({tag, "_rrs_cycles"}, cnt, SETTLE);
    check({tag, "_access_en"}, bus.vf_access_en, 1);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  // Drive ready (optionally with random stalls) and pop expected ids on each accept.
  task automatic run_walk(input int n, input bit stall);
    int              guard = 0;
    bit              prev_stall = 1'b0;
    logic [ID_W-1:0] prev_id = '0;
    logic [ID_W-1:0] exp;
    for (int i = 0; i < n; i++) exp_q.push_back(ID_W'(i));
    while (exp_q.size() > 0 && guard < 2000) begin
      if (prev_stall) begin
        check("stall_valid", bus.vf_rst_valid, 1);
        check("stall_id", bus.vf_rst_id, prev_id);
      end
      if (bus.vf_rst_valid) begin
        bus.vf_rst_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus.vf_rst_ready) begin
          exp = exp_q.pop_front();
          check("walk_id", bus.vf_rst_id, exp);
        end
        prev_stall = !bus.vf_rst_ready;
        prev_id    = bus.vf_rst_id;
      end else begin
        bus.vf_rst_ready = 1'b0;
        prev_stall       = 1'b0;
      end
      tick();
      guard++;
    end
    bus.vf_rst_ready = 1'b0;
    check("walk_remaining", exp_q.size(), 0);
    check("walk_end_valid", bus.vf_rst_valid, 0);
    check("walk_end_busy", bus.busy, 0);
    check("walk_end_rrs", bus.vf_cfg_rrs, 0);
    check("walk_end_id", bus.vf_rst_id, 0);
  endtask

  initial begin
    int cnt;
    rst                = 1'b1;
    bus.ctrl_wr_en     = 1'b0;
    bus.ctrl_vf_enable = 1'b0;
    bus.ctrl_num_vfs   = '0;
    bus.vf_outstanding = 1'b0;
    bus.vf_rst_ready   = 1'b0;
    tick();
    tick();
    check("rst_valid", bus.vf_rst_valid, 0);
    check("rst_access", bus.vf_access_en, 0);
    check("rst_rrs", bus.vf_cfg_rrs, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_num", bus.num_vfs_q, 0);
    check("rst_reject", bus.wr_reject, 0);
    rst = 1'b0;
    tick();

    // Enable 4 VFs: exactly SETTLE cycles of RRS
    do_write(1'b1, 16'd4);
    check("settle_busy", bus.busy, 1);
    settle_and_check("en4");
    check("en4_num", bus.num_vfs_q, 4);

    // NumVFs locked while enabled
    do_write(1'b1, 16'd2);
    check("locked_reject", bus.wr_reject, 1);
    check("locked_num", bus.num_vfs_q, 4);
    tick();
    check("locked_reject_pulse", bus.wr_reject, 0);
    do_write(1'b1, 16'd4);
    check("same_num_noop", bus.wr_reject, 0);
    check("same_num_access", bus.vf_access_en, 1);

    // Disable with nothing outstanding: one QUIESCE cycle then walk 0..3
    do_write(1'b0, 16'd0);
    check("quiesce_rrs", bus.vf_cfg_rrs, 1);
    check("quiesce_access", bus.vf_access_en, 0);
    check("quiesce_valid", bus.vf_rst_valid, 0);
    tick();
    check("walk_start_valid", bus.vf_rst_valid, 1);
    run_walk(4, 1'b0);
    check("walk4_qto", bus.quiesce_to, 0);

    // Clamp 40 -> 16, walk all with random ready stalls
    do_write(1'b1, 16'd40);
    check("clamp_num", bus.num_vfs_q, TOTAL);
    settle_and_check("en40");
    do_write(1'b0, 16'd0);
    run_walk(TOTAL, 1'b1);

    // Quiesce timeout with outstanding stuck high
    do_write(1'b1, 16'd3);
    settle_and_check("en3");
    bus.vf_outstanding = 1'b1;
    do_write(1'b0, 16'd0);
    cnt = 0;
    while (!bus.quiesce_to && cnt < 100) begin
      cnt++;
      tick();
    end
    check("qto_cycles", cnt, QTO);
    check("qto_pulse", bus.quiesce_to, 1);
    check("qto_walk_valid", bus.vf_rst_valid, 1);
    check("qto_walk_id", bus.vf_rst_id, 0);
    do_write(1'b1, 16'd3);
    check("qto_pulse_once", bus.quiesce_to, 0);
    check("walk_write_reject", bus.wr_reject, 1);
    check("walk_write_valid", bus.vf_rst_valid, 1);
    bus.vf_outstanding = 1'b0;
    run_walk(3, 1'b0);

    // Writes in DISABLED: enable with zero rejected; disable updates NumVFs
    do_write(1'b1, 16'd0);
    check("zero_reject", bus.wr_reject, 1);
    check("zero_busy", bus.busy, 0);
    check("zero_num", bus.num_vfs_q, 0);
    do_write(1'b0, 16'd7);
    check("dis_wr_reject", bus.wr_reject, 0);
    check("dis_wr_num", bus.num_vfs_q, 7);
    check("dis_wr_busy", bus.busy, 0);

    // Reset while walking at id 2
    do_write(1'b1, 16'd4);
    settle_and_check("en4b");
    do_write(1'b0, 16'd0);
    bus.vf_rst_ready = 1'b1;
    cnt = 0;
    while (!(bus.vf_rst_valid && bus.vf_rst_id == ID_W'(2)) && cnt < 20) begin
      cnt++;
      tick();
    end
    check("rstwalk_reach_id2", bus.vf_rst_id, 2);
    bus.vf_rst_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rstwalk_valid", bus.vf_rst_valid, 0);
    check("rstwalk_num", bus.num_vfs_q, 0);
    check("rstwalk_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_valid", bus.vf_rst_valid, 0);
    do_write(1'b1, 16'd4);
    settle_and_check("post_rst");
    check("post_rst_num", bus.num_vfs_q, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
